adc_capture_ctrl: RTL

//  Sequences capture of ADC Y samples (from adc_y, already in clk domain) into a

---
 rtl/adc_capture_ctrl_pkg.sv | 17 +
 rtl/adc_trigger_detect.sv | 52 +++++
 rtl/adc_capture_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/adc_capture_ctrl_pkg.sv
// Shared definitions for the ADC capture controller and its host readout.
//  - Default widths for samples, buffer addresses and the decimation ratio.
//  - Capture FSM state encoding (2 bits), so readout logic decodes the same values.
package adc_capture_ctrl_pkg;

  localparam int DATA_BITS_DEF  = 10;
  localparam int ADDR_BITS_DEF  = 9;
  localparam int DECIM_BITS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/adc_trigger_detect.sv
// Level-crossing trigger detector for the capture controller.
// Ports:
//  clk, reset_n        clock, async active-low reset
//  clear               forget the previous sample (new arm)
//  enable              detector active (controller is ARMED)
//  sample_valid/data   incoming sample
//  trig_level          unsigned threshold; equality counts as "above"
//  trig_rising         1 = below->above crossing, 0 = above->below
//  trig_force          fire on the first enabled sample
//  trig                1-cycle pulse, combinational on the triggering sample
module adc_trigger_detect
  import adc_capture_ctrl_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 sample_valid,
  input  logic [DATA_BITS-1:0] sample_data,
  input  logic [DATA_BITS-1:0] trig_level,
  input  logic                 trig_rising,
  input  logic                 trig_force,
  output logic                 trig
);

  logic [DATA_BITS-1:0] prev_q;
  logic                 prev_vld_q;
  logic                 cur_above, prev_above, edge_hit;

  assign cur_above  = sample_data >= trig_level;
  assign prev_above = prev_q >= trig_level;
  assign edge_hit   = trig_rising ? (!prev_above && cur_above)
                                  : (prev_above && !cur_above);

  // Without force, the first sample after arm only seeds prev_q.
  assign trig = enable && sample_valid && (trig_force || (prev_vld_q && edge_hit));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else if (clear) begin
      prev_vld_q <= 1'b0;
    end else if (enable && sample_valid) begin
      prev_q     <= sample_data;
      prev_vld_q <= 1'b1;
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer and single-port sample-buffer arbiter.
// Arm -> wait for trigger -> store 2**ADDR_BITS decimated samples -> DONE,
// then the host reads the buffer back through the same port.
// Ports:
//  clk, reset_n                 clock, async active-low reset
//  arm                          start/restart a capture (wins over host reads)
//  sample_valid/sample_data     ADC samples
//  trig_level/rising/force      trigger setup
//  decim                        keep 1 of every decim+1 samples
//  buf_addr/we/wdata, buf_rdata buffer port (sync read, 1-cycle latency)
//  rd_valid/rd_addr/rd_ready    host read request handshake
//  rd_data_valid/rd_data        host read response, 1 cycle after accept
//  busy, done                   ARMED|CAPTURE, DONE
module adc_capture_ctrl
  import adc_capture_ctrl_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int ADDR_BITS  = ADDR_BITS_DEF,
  parameter int DECIM_BITS = DECIM_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  arm,
  input  logic                  sample_valid,
  input  logic [DATA_BITS-1:0]  sample_data,
  input  logic [DATA_BITS-1:0]  trig_level,
  input  logic                  trig_rising,
  input  logic                  trig_force,
  input  logic [DECIM_BITS-1:0] decim,
  output logic [ADDR_BITS-1:0]  buf_addr,
  output logic                  buf_we,
  output logic [DATA_BITS-1:0]  buf_wdata,
  input  logic [DATA_BITS-1:0]  buf_rdata,
  input  logic                  rd_valid,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic                  rd_ready,
  output logic                  rd_data_valid,
  output logic [DATA_BITS-1:0]  rd_data,
  output logic                  busy,
  output logic                  done
);

  cap_state_e            state_q, state_d;
  logic [ADDR_BITS-1:0]  wptr_q, wr_addr_q;
  logic [DATA_BITS-1:0]  wdata_q;
  logic [DECIM_BITS-1:0] dcnt_q;
  logic                  we_q, full_q, rd_vld_q;
  logic                  trig, cap_smp, store, rd_acc;

  adc_trigger_detect #(.DATA_BITS(DATA_BITS)) u_trig (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (arm),
    .enable       (state_q == ST_ARMED && !arm),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .trig_level   (trig_level),
    .trig_rising  (trig_rising),
    .trig_force   (trig_force),
    .trig         (trig)
  );

  // full_q marks the last store issued; no samples are taken during its
  // write cycle, and the FSM moves to DONE once that write is on the bus.
  assign cap_smp = trig || (state_q == ST_CAPTURE && sample_valid && !full_q && !arm);
  assign store   = trig || (state_q == ST_CAPTURE && sample_valid && !full_q && !arm
                            && dcnt_q == '0);

  // reset_n gates acceptance so buf_addr holds its reset value during reset.
  assign rd_ready      = reset_n && (state_q == ST_IDLE || state_q == ST_DONE) && !arm;
  assign rd_acc        = rd_valid && rd_ready;
  assign buf_addr      = rd_acc ? rd_addr : wr_addr_q;
  assign buf_we        = we_q;
  assign buf_wdata     = wdata_q;
  assign rd_data_valid = rd_vld_q;
  assign rd_data       = rd_vld_q ? buf_rdata : '0;
  assign busy          = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign done          = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (arm) state_d = ST_ARMED;
      ST_ARMED:   if (arm) state_d = ST_ARMED;
                  else if (trig) state_d = ST_CAPTURE;
      ST_CAPTURE: if (arm) state_d = ST_ARMED;
                  else if (full_q) state_d = ST_DONE;
      ST_DONE:    if (arm) state_d = ST_ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q    <= '0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
      dcnt_q    <= '0;
      we_q      <= 1'b0;
      full_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_vld_q <= rd_acc;
      if (arm) begin
        wptr_q <= '0;
        dcnt_q <= '0;
        we_q   <= 1'b0;
        full_q <= 1'b0;
      end else begin
        we_q <= store;
        if (store) begin
          wr_addr_q <= wptr_q;
          wdata_q   <= sample_data;
          wptr_q    <= wptr_q + 1'b1;
          if (&wptr_q) full_q <= 1'b1;
        end
        // Trigger sample is count 0; decim is compared live each sample.
        if (cap_smp) dcnt_q <= (dcnt_q == decim) ? '0 : dcnt_q + 1'b1;
      end
    end
  end

endmodule
